// File: rtl/hex_segment_reader.sv
// Recovers hex digit values from a multiplexed active-low 7-segment bus with per-digit debounce.
// Optional macro HEXREAD_BLANK_EN: treat 7'h7F (all segments off) as a legal blank digit.
module hex_segment_reader #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned STABLE_COUNT = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sample_en,
  input  logic [6:0]              segments,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] hex_digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   pattern_error,
  output logic                    update,
  output logic                    sel_error
);

  localparam int unsigned IdxW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0]  StableCnt = 4'(STABLE_COUNT);
  localparam logic [6:0]  BlankPat  = 7'h7F;

`ifdef HEXREAD_BLANK_EN
  localparam bit BlankEn = 1'b1;
`else
  localparam bit BlankEn = 1'b0;
`endif

  // Stage 1: capture
  logic            s1_valid_q;
  logic [6:0]      s1_pat_q;
  logic [IdxW-1:0] s1_idx_q;
  logic            sel_error_q;
  logic            sel_onehot;
  logic [IdxW-1:0] sel_idx;

  // Stage 2: per-digit filter and committed outputs
  logic [NUM_DIGITS-1:0][6:0] cand_q, cand_d;
  logic [NUM_DIGITS-1:0][3:0] cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]      valid_q, valid_d;
  logic [NUM_DIGITS-1:0]      perr_q, perr_d;
  logic                       update_q, update_d;

  logic       dec_legal;
  logic [3:0] dec_value;
  logic       dec_blank;

  assign sel_onehot = ($countones(digit_sel) == 1);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_sel[i]) sel_idx = IdxW'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_pat_q    <= '0;
      s1_idx_q    <= '0;
      sel_error_q <= 1'b0;
    end else begin
      s1_valid_q  <= sample_en && sel_onehot;
      sel_error_q <= sample_en && !sel_onehot;
      if (sample_en && sel_onehot) begin
        s1_pat_q <= segments;
        s1_idx_q <= sel_idx;
      end
    end
  end

  always_comb begin
    dec_legal = 1'b1;
    dec_value = 4'h0;
    case (s1_pat_q)
      7'h40:   dec_value = 4'h0;
      7'h79:   dec_value = 4'h1;
      7'h24:   dec_value = 4'h2;
      7'h30:   dec_value = 4'h3;
      7'h19:   dec_value = 4'h4;
      7'h12:   dec_value = 4'h5;
      7'h02:   dec_value = 4'h6;
      7'h78:   dec_value = 4'h7;
      7'h00:   dec_value = 4'h8;
      7'h18:   dec_value = 4'h9;
      7'h08:   dec_value = 4'hA;
      7'h03:   dec_value = 4'hB;
      7'h46:   dec_value = 4'hC;
      7'h21:   dec_value = 4'hD;
      7'h06:   dec_value = 4'hE;
      7'h0E:   dec_value = 4'hF;
      default: dec_legal = 1'b0;
    endcase
    dec_blank = BlankEn && (s1_pat_q == BlankPat);
  end

  always_comb begin
    logic commit_now;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    hex_d    = hex_q;
    valid_d  = valid_q;
    perr_d   = perr_q;
    update_d = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      commit_now = 1'b0;
      if (s1_valid_q && (s1_idx_q == IdxW'(i))) begin
        if (s1_pat_q == cand_q[i]) begin
          // Saturated counter means this pattern already committed; stay silent.
          if (cnt_q[i] < StableCnt) begin
            cnt_d[i]   = cnt_q[i] + 4'd1;
            commit_now = ((cnt_q[i] + 4'd1) == StableCnt);
          end
        end else begin
          cand_d[i]  = s1_pat_q;
          cnt_d[i]   = 4'd1;
          commit_now = (StableCnt == 4'd1);
        end
      end
      if (commit_now) begin
        update_d = 1'b1;
        if (dec_legal) begin
          hex_d[i]   = dec_value;
          valid_d[i] = 1'b1;
          perr_d[i]  = 1'b0;
        end else if (dec_blank) begin
          valid_d[i] = 1'b0;
          perr_d[i]  = 1'b0;
        end else begin
          valid_d[i] = 1'b0;
          perr_d[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cand_q   <= {NUM_DIGITS{BlankPat}};
      cnt_q    <= '0;
      hex_q    <= '0;
      valid_q  <= '0;
      perr_q   <= '0;
      update_q <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      hex_q    <= hex_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      update_q <= update_d;
    end
  end

  assign hex_digits    = hex_q;
  assign digit_valid   = valid_q;
  assign pattern_error = perr_q;
  assign update        = update_q;
  assign sel_error     = sel_error_q;

endmodule

// File: doc/hex_segment_reader.md
# hex_segment_reader

Recovers hex digit values from a time-multiplexed, active-low 7-segment display bus, the inverse of the board's hex-to-segment decoding. Each sample is a segment pattern plus a one-hot digit select. The block keeps a per-digit candidate pattern and commits it only after `STABLE_COUNT` consecutive identical samples. It sits between the display drive lines and self-check or scoreboard logic, confirming that what is shown on the HEX displays matches intended values.

## Interface
Parameters:
- `NUM_DIGITS`, 4: number of multiplexed digit positions (1..8).
- `STABLE_COUNT`, 3: consecutive identical samples needed to commit a digit (1..15).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous reset.
- `sample_en`  in  1  qualifies the current `segments`/`digit_sel` as a sample.
- `segments`  in  7  active-low pattern, bit 0 = seg a … bit 6 = seg g.
- `digit_sel`  in  `NUM_DIGITS`  active-high one-hot digit position.
- `hex_digits`  out  4*`NUM_DIGITS`  committed values; digit i at bits [4i+3:4i].
- `digit_valid`  out  `NUM_DIGITS`  digit i holds a committed, legal value.
- `pattern_error`  out  `NUM_DIGITS`  last commit for digit i was an illegal pattern.
- `update`  out  1  one-cycle pulse on any commit.
- `sel_error`  out  1  one-cycle pulse: `sample_en` with `digit_sel` not one-hot.

## Operation
- Legal patterns, value=pattern hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=18, A=08, B=03, C=46, D=21, E=06, F=0E
  - Any other pattern is illegal.
- Stage 1, capture:
  - `sample_en`=1 and `digit_sel` one-hot: register pattern and digit index; stage-1 valid=1.
  - `sample_en`=1 and `digit_sel` zero or multi-hot: sample dropped, `sel_error` pulses next cycle.
  - `sample_en`=0: stage-1 valid=0.
- Stage 2, filter and commit, per digit i (candidate `cand[i]` 7b, counter `cnt[i]` saturating at `STABLE_COUNT`):
  - Pattern == `cand[i]` and `cnt[i]` < `STABLE_COUNT`: increment.
  - Pattern == `cand[i]` and `cnt[i]` == `STABLE_COUNT`: no action; no re-commit.
  - Pattern != `cand[i]`: `cand[i]`=pattern, `cnt[i]`=1.
  - Commit occurs when `cnt[i]` reaches `STABLE_COUNT`. With `STABLE_COUNT`=1, every new pattern commits.
- Commit of a legal pattern: `hex_digits[i]`=value, `digit_valid[i]`=1, `pattern_error[i]`=0, `update`=1.
- Commit of an illegal pattern: `hex_digits[i]` unchanged, `digit_valid[i]`=0, `pattern_error[i]`=1, `update`=1.
- Between commits, committed outputs hold even while a new candidate accumulates.
- Samples for different digits are independent; interleaving never resets another digit's counter.

## Timing
- Reset values:
  - `hex_digits`=0, `digit_valid`=0, `pattern_error`=0, `update`=0, `sel_error`=0
  - all `cand`=7'h7F, all `cnt`=0, stage-1 valid=0
- Latency:
  - Sample registered at edge k; counter/commit at edge k+1.
  - Outputs and `update` are visible after edge k+1.
- Throughput: one sample per clock; back-to-back `sample_en` is allowed.
- Reset asserted mid-operation: any in-flight stage-1 sample is discarded; everything returns to reset values on that edge.
- `update` and `sel_error` are single-cycle pulses, never stretched. Both may assert in the same cycle (commit from sample k, bad select from sample k+1).

## Configuration
- `HEXREAD_BLANK_EN`:
  - Defined: 7'h7F (all segments off) is a legal blank. Its commit sets `digit_valid[i]`=0 and `pattern_error[i]`=0, holds `hex_digits[i]`, and pulses `update`.
  - Undefined: 7'h7F is illegal and commits as `pattern_error[i]`=1.
  - Because `cand` resets to 7'h7F, the first blank sample after reset gives `cnt`=1 under either setting (reset `cnt`=0, then increments on match).

## Test plan
- Reset, then digit 0 pattern 7'h24 for 3 consecutive samples -> after the 3rd sample's edge+1: `hex_digits[3:0]`=2, `digit_valid[0]`=1, one `update` pulse; a 4th identical sample gives no `update`.
- Digit 1: 7'h12, 7'h12, 7'h79, 7'h79, 7'h79 -> single commit, `hex_digits[7:4]`=1; the value 5 never appears.
- Interleave digit 0 = 7'h0E and digit 2 = 7'h46, 3 samples each, alternating -> both commit (F and C) with two separate `update` pulses.
- Digit 3 pattern 7'h55 ×3 -> `pattern_error[3]`=1, `digit_valid[3]`=0, `hex_digits[15:12]` unchanged.
- `sample_en` with `digit_sel`=4'b0110, then 4'b0000 -> two `sel_error` pulses; no counter changes.
- 7'h7F ×3 on digit 0:
  - With `HEXREAD_BLANK_EN`: `valid`=0, `error`=0, `update` pulse.
  - Without it: `pattern_error[0]`=1.
  - Reset asserted between the 2nd and 3rd samples: no commit.
